// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, func3
// encodings, byte-lane type and the store/misalignment formatting helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef logic [1:0] lane_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Byte enables for a store; unknown func3 codes behave as a full word.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input lane_t lane);
    logic [3:0] be;
    case (f3)
      SB:      be = 4'b0001 << lane;
      SH:      be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enabled lane always carries it.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      SB:      w = {4{d[7:0]}};
      SH:      w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Halves must sit on an even byte, words on a word boundary.
  function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                         input lane_t lane);
    logic is_half;
    logic is_byte;
    is_half = is_store ? (f3 == SH) : ((f3 == LH) || (f3 == LHU));
    is_byte = is_store ? (f3 == SB) : ((f3 == LB) || (f3 == LBU));
    if (is_byte) return 1'b0;
    if (is_half) return lane[0];
    return (lane != 2'b00);
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a returned memory word and applies
// sign or zero extension according to func3.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  func3,
  input  lane_t       lane,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension; unknown func3 returns the word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LBU:     data = {24'd0, byte_sel};
      LHU:     data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: captures a load/store from the datapath,
// issues one word-aligned handshaked memory request, formats the result
// and stalls the PC until the access completes.
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned
// half/word accesses instead of issuing them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmem_read_en,
  input  logic              dmem_write_en,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        func3_q;
  logic [DATA_W-1:0] wdata_q;
  logic              store_q;
  logic              mis_q;
  logic              capture;
  logic              access;
  logic              mis_now;
  logic [DATA_W-1:0] aligned;

  // Reset also masks a new access so stall falls as soon as rst_n is low.
  assign access = (dmem_read_en | dmem_write_en) & rst_n;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_now = is_misaligned(dmem_write_en, func3, addr[1:0]);
`else
  assign mis_now = 1'b0;
`endif

  load_align u_load_align (
    .rdata (mem_rdata),
    .func3 (func3_q),
    .lane  (addr_q[1:0]),
    .data  (aligned)
  );

  // Next-state and request outputs; memory-side outputs are zero unless requesting.
  always_comb begin
    state_d    = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = mis_now ? DONE : REQ;
        end
      end
      REQ: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_be    = store_q ? store_be(func3_q, addr_q[1:0]) : 4'b1111;
        mem_wdata = store_q ? store_wdata(func3_q, wdata_q) : '0;
        if (mem_gnt) state_d = store_q ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) state_d = WAIT == state ? DONE : state;
      end
      default: begin
        misaligned = mis_q;
        state_d    = IDLE;
      end
    endcase
  end

  // State register, access capture and registered load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      func3_q   <= 3'b000;
      wdata_q   <= '0;
      store_q   <= 1'b0;
      mis_q     <= 1'b0;
      load_data <= '0;
    end else begin
      state <= state_d;
      if (capture) begin
        addr_q  <= addr;
        func3_q <= func3;
        wdata_q <= store_data;
        store_q <= dmem_write_en;
        mis_q   <= mis_now;
        if (mis_now && !dmem_write_en) load_data <= '0;
      end
      if ((state == WAIT) && mem_rvalid) load_data <= aligned;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected requests and load results
// are queued when a transaction is driven and compared when the DUT
// produces them. Honours LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dmem_read_en = 1'b0;
  logic        dmem_write_en = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        stall;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'hBAD0BAD0;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } req_t;

  req_t        req_q[$];
  logic [31:0] load_q[$];
  logic [31:0] last_load = '0;
  int          num_compared = 0;
  int          num_mismatched = 0;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dmem_read_en  (dmem_read_en),
    .dmem_write_en (dmem_write_en),
    .func3         (func3),
    .addr          (addr),
    .store_data    (store_data),
    .load_data     (load_data),
    .stall         (stall),
    .misaligned    (misaligned),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Counts every comparison and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_compared++;
    if (obs !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'b000) return 4'b0001 << a;
    if (f3 == 3'b001) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'b000) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3 == 3'b001) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
    logic [31:0] bs;
    logic [31:0] hs;
    bs = rd >> (8 * a);
    hs = rd >> (16 * a[1]);
    case (f3)
      3'b000:  return {{24{bs[7]}}, bs[7:0]};
      3'b001:  return {{16{hs[15]}}, hs[15:0]};
      3'b100:  return {24'd0, bs[7:0]};
      3'b101:  return {16'd0, hs[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic model_mis(input logic st, input logic [2:0] f3, input logic [1:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    logic half;
    logic word;
    half = st ? (f3 == 3'b001) : (f3 == 3'b001 || f3 == 3'b101);
    word = st ? !(f3 == 3'b000 || f3 == 3'b001)
              : !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101);
    return (half && a[0]) || (word && (a != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  // Drives one load/store, plays the memory side and scores the outcome.
  task automatic applyStimulus(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input int gnt_dly, input logic [31:0] rd);
    logic  st;
    logic  exp_mis;
    int    stall_cycles;
    int    req_cyc;
    int    gnt_cyc;
    logic  req_seen;
    logic  done;
    req_t  snap;
    req_t  exp_r;
    logic [31:0] exp_ld;
    st      = wr_en;
    exp_mis = model_mis(st, f3, a[1:0]);
    if (!exp_mis)
      req_q.push_back('{a: {a[31:2], 2'b00}, be: st ? model_be(f3, a[1:0]) : 4'b1111,
                        wd: st ? model_wdata(f3, sd) : 32'h0, we: st});
    if (!st) load_q.push_back(exp_mis ? 32'h0 : model_load(f3, a[1:0], rd));
    dmem_read_en  = rd_en;
    dmem_write_en = wr_en;
    func3         = f3;
    addr          = a;
    store_data    = sd;
    stall_cycles  = 0;
    req_cyc       = -1;
    gnt_cyc       = -10;
    req_seen      = 1'b0;
    done          = 1'b0;
    snap          = '0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hBAD0BAD0;
      if (mem_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          req_cyc  = cyc;
          snap     = '{a: mem_addr, be: mem_be, wd: mem_wdata, we: mem_we};
          if (req_q.size() == 0) checkOutput("unexpected_req", 32'd1, 32'd0);
          else begin
            exp_r = req_q.pop_front();
            checkOutput("mem_addr", mem_addr, exp_r.a);
            checkOutput("mem_be", {28'd0, mem_be}, {28'd0, exp_r.be});
            checkOutput("mem_wdata", mem_wdata, exp_r.wd);
            checkOutput("mem_we", {31'd0, mem_we}, {31'd0, exp_r.we});
          end
        end else begin
          checkOutput("req_stable", {mem_addr ^ snap.a} | {28'd0, mem_be ^ snap.be}
                      | (mem_wdata ^ snap.wd) | {31'd0, mem_we ^ snap.we}, 32'd0);
        end
        if (cyc - req_cyc >= gnt_dly) begin
          mem_gnt = 1'b1;
          gnt_cyc = cyc;
        end
      end else if (!st && cyc == gnt_cyc + 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
      end
      #1;
      if (stall) stall_cycles++;
      else begin
        done = 1'b1;
        exp_ld = st ? last_load : load_q.pop_front();
        checkOutput("load_data", load_data, exp_ld);
        checkOutput("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
        checkOutput("idle_mem_be", {28'd0, mem_be}, 32'd0);
        last_load = exp_ld;
      end
      @(posedge clk); #1;
    end
    checkOutput("completed", {31'd0, done}, 32'd1);
    checkOutput("req_issued", {31'd0, req_seen}, {31'd0, !exp_mis});
    checkOutput("stall_cycles", stall_cycles,
                exp_mis ? 32'd1 : (st ? 32'd2 : 32'd3) + gnt_dly);
    dmem_read_en  = 1'b0;
    dmem_write_en = 1'b0;
    mem_gnt       = 1'b0;
    mem_rvalid    = 1'b0;
    req_q.delete();
    load_q.delete();
  endtask

  initial begin
    $display("[TB] load_store_unit bench start");
    #12;
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_misaligned", {31'd0, misaligned}, 32'd0);
    checkOutput("rst_mem_be", {28'd0, mem_be}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_load_data", load_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the block's intended use.
    applyStimulus(1, 0, 3'b010, 32'h104, 32'h0, 0, 32'hDEADBEEF);
    applyStimulus(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF1234);
    applyStimulus(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234);
    applyStimulus(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 3, 32'h0);
    applyStimulus(0, 1, 3'b000, 32'h201, 32'h00000055, 0, 32'h0);
    applyStimulus(1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF1234);
    applyStimulus(1, 0, 3'b101, 32'h100, 32'h0, 2, 32'h12348001);
    applyStimulus(1, 0, 3'b001, 32'h100, 32'h0, 0, 32'h12348001);
    applyStimulus(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 1, 32'h0);
    applyStimulus(1, 0, 3'b011, 32'h400, 32'h0, 0, 32'h13572468);
    applyStimulus(1, 1, 3'b010, 32'h500, 32'h11223344, 0, 32'hFFFFFFFF);
    applyStimulus(1, 0, 3'b010, 32'h106, 32'h0, 0, 32'hA5A5A5A5);
    applyStimulus(0, 1, 3'b001, 32'h203, 32'h0000BEEF, 0, 32'h0);

    // An rvalid arriving while idle must not touch load_data.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checkOutput("idle_rvalid_ignored", load_data, last_load);

    // Mixed random traffic.
    for (int i = 0; i < 24; i++) begin
      logic        w;
      logic [2:0]  f;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = {20'd0, 12'($urandom)};
      applyStimulus(!w, w, f, a, $urandom, $urandom_range(0, 2), $urandom);
    end

    // Reset pulsed while a load waits for its data.
    dmem_read_en = 1'b1;
    func3        = 3'b010;
    addr         = 32'h104;
    @(posedge clk); #1;
    checkOutput("rst_test_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checkOutput("rst_test_wait_stall", {31'd0, stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    dmem_read_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    #1;
    checkOutput("post_rst_rvalid_ignored", load_data, 32'd0);
    checkOutput("post_rst_stall", {31'd0, stall}, 32'd0);
    last_load = 32'd0;

    applyStimulus(1, 0, 3'b000, 32'h7, 32'h0, 0, 32'h7F000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 1, expected 0");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
